// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the signed shift-add multiplier sequencer.
package mult_pkg;

    localparam int N  = 8;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADB = 3'd1,
        START = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s == START) || (s == ADD) || (s == SHIFT);
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Add/shift iteration counter: synchronous clear, enable, saturating at N-1 with a terminal flag.
module iter_counter #(
    parameter int N = mult_pkg::N
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign term_o = (count_q == CW'(N - 1));

    // Holding at the terminal count keeps the counter inside 0..N-1 even if enable lingers.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !term_o) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control sequencer for the signed shift-add multiplier: drives clear/load/add/shift strobes
// to the X, A and B registers and runs one multiply per Run press.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int N = mult_pkg::N
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_AX,
    output logic Ld_B,
    output logic Ld_AX,
    output logic Fn,
    output logic Shift_En,
    output logic Busy
);

    state_t state_q;
    state_t state_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;

    iter_counter #(
        .N (N)
    ) u_iter_counter (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_o (cnt_last)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The final ADD uses subtraction because the multiplier's MSB carries negative weight.
    always_comb begin
        state_d  = state_q;
        Clr_AX   = 1'b0;
        Ld_B     = 1'b0;
        Ld_AX    = 1'b0;
        Fn       = 1'b0;
        Shift_En = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Run) begin
                    state_d = START;
                end else if (ClearA_LoadB) begin
                    state_d = LOADB;
                end
            end
            LOADB: begin
                Clr_AX  = 1'b1;
                Ld_B    = 1'b1;
                state_d = IDLE;
            end
            START: begin
                Clr_AX  = 1'b1;
                cnt_clr = 1'b1;
                state_d = ADD;
            end
            ADD: begin
                Ld_AX   = M;
                Fn      = cnt_last;
                state_d = SHIFT;
            end
            SHIFT: begin
                Shift_En = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = ADD;
                end
            end
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy = state_is_busy(state_q);

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer for the lab 5 signed shift-add multiplier (8x8 → 16-bit result in A:B, sign/extension bit in X).
- Sits directly upstream of the X bit register and the A/B shift registers.
- Issues clear, load, add/subtract and shift strobes to those registers, and samples the multiplier LSB M back from register B.
- Runs one full multiplication per Run press, then waits for Run to be released.

Parameters:
- N, 8, operand width; number of add/shift iterations.
- CW, $clog2(N), iteration counter width (derived; not overridden).

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  level, already synchronized and debounced; rising level starts a multiply.
- ClearA_LoadB  in  1  level, already synchronized; loads B from switches and clears A and X.
- M  in  1  current LSB of register B.
- Clr_AX  out  1  synchronous clear strobe to A and X.
- Ld_B  out  1  parallel-load strobe to B.
- Ld_AX  out  1  load strobe to A and X (adder result), i.e. the Load input of the X bit register.
- Fn  out  1  adder function: 0 = A+S, 1 = A−S.
- Shift_En  out  1  arithmetic right shift of X:A:B by one.
- Busy  out  1  high from START through the final SHIFT.

Behaviour:
Reset:
- Reset_n low forces state IDLE and count 0 immediately, independent of Clk.
- All outputs are 0 while in reset.
- A Reset_n assertion mid-multiply aborts the operation; no further strobes are issued.
- Datapath register contents are the datapath's concern.

States (typedef enum):
- IDLE
- LOADB
- START
- ADD
- SHIFT
- DONE

Transitions:
- IDLE: Run=1 → START. Else ClearA_LoadB=1 → LOADB. Run has priority when both are high.
- LOADB: one cycle; Clr_AX=1, Ld_B=1. Then → IDLE. Releasing ClearA_LoadB is not required; while it stays high, LOADB repeats every other cycle (harmless).
- START: one cycle; Clr_AX=1; count cleared to 0. Then → ADD.
- ADD: one cycle.
  - Ld_AX = M (combinational from M in this state only).
  - Fn = 1 if count == N−1, else 0.
  - Then → SHIFT.
- SHIFT: one cycle; Shift_En=1. If count == N−1 → DONE; else count+1 → ADD.
- DONE: all strobes 0. Run=0 → IDLE; Run=1 holds in DONE, so there is no auto-restart.

Outputs:
- Fn is 0 in every state except ADD with count == N−1. Outside ADD it has no effect on the registers.
- Strobes are mutually exclusive per cycle, except Clr_AX+Ld_B in LOADB.

Latency and boundaries:
- Multiply latency from the START cycle to the last SHIFT: 2N+1 cycles (17 for N=8).
- The result is valid in A:B on the first DONE cycle.
- Busy=1 exactly in START, ADD and SHIFT.
- M is sampled only in ADD, so M changing during SHIFT is ignored.
- Run dropping mid-multiply does not abort; the sequence completes and DONE exits on the next cycle.
- ClearA_LoadB is ignored in every state except IDLE.
- Counter wrap: the counter never exceeds N−1; it is reset in START and never increments past the final SHIFT.

Decomposition:
- Package mult_pkg: the N constant and typedef enum logic [2:0] state_t {IDLE, LOADB, START, ADD, SHIFT, DONE}.
- One sub-module, iter_counter (CW-bit; synchronous clear and enable; async active-low reset; terminal flag at N−1), instanced by the FSM.
- Next-state and output logic stay in mult_seq_ctrl as always_comb; the state register is always_ff with async reset.

Test Plan:
- Reset mid-op: drive Run=1, pulse Reset_n low during the third ADD → all outputs 0 during reset; state IDLE after release; no strobes until the next Run.
- Load: ClearA_LoadB=1 for 1 cycle in IDLE → exactly one cycle with Clr_AX=1 and Ld_B=1, then IDLE; Busy stays 0.
- Multiply with M pattern 0x07 (bits 1,1,1,0,0,0,0,0 LSB first) → START at t0, Ld_AX=1 on the ADD cycles at t1, t3, t5 only, Fn=0 throughout, Shift_En on the 8 even offsets t2..t16, DONE at t17.
- Negative multiplier, M pattern 0x80 → Ld_AX=1 only on the 8th ADD (t15) with Fn=1 in that cycle; Fn=0 in all other cycles.
- Run held high 40 cycles → exactly one multiply sequence; remains in DONE; after Run falls, IDLE one cycle later; a second Run press produces a second identical sequence beginning with Clr_AX.
- Run and ClearA_LoadB asserted together in IDLE → START taken (Clr_AX=1, Ld_B=0); ClearA_LoadB toggling during the multiply → no Ld_B pulses.
